// File: rtl/fetch_unit_if.sv
// Instruction memory read channel between the fetch stage (master) and the memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack channel, holds the instruction
// register and commits the next PC when execute retires the current instruction.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    input  logic         retire,
    input  logic [1:0]   pc_src,
    input  logic [31:0]  imm_ext,
    input  logic [31:0]  alu_result,
    output logic         misaligned
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        VALID = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        req_r;
    logic        valid_r;
    logic        misaligned_r;
    logic [31:0] target_s;

    // Encoding 2'b11 falls back to the sequential successor.
    function automatic logic [31:0] select_target(
        input logic [1:0]  src,
        input logic [31:0] pc_v,
        input logic [31:0] imm_v,
        input logic [31:0] alu_v
    );
        logic [31:0] t;
        case (src)
            2'b01:   t = pc_v + imm_v;
            2'b10:   t = {alu_v[31:1], 1'b0};
            default: t = pc_v + 32'd4;
        endcase
        return t;
    endfunction

    // Next-PC candidate, only consumed on a retire edge in VALID.
    always_comb begin
        target_s = select_target(pc_src, pc_r, imm_ext, alu_result);
    end

    // Fetch control FSM with registered request, valid and fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            instr_r      <= NOP_INSTR;
            req_r        <= 1'b0;
            valid_r      <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr_r <= imem.imem_rdata;
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= VALID;
                    end
                end
                VALID: begin
                    if (retire) begin
                        valid_r <= 1'b0;
                        // A misaligned target is reported but never committed.
                        if (target_s[1]) begin
                            misaligned_r <= 1'b1;
                            state_r      <= FAULT;
                        end else begin
                            pc_r    <= target_s;
                            req_r   <= 1'b1;
                            state_r <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    req_r        <= 1'b0;
                    valid_r      <= 1'b0;
                    misaligned_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_r + 32'd4;
    assign instr          = instr_r;
    assign instr_valid    = valid_r;
    assign misaligned     = misaligned_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance at RESET_PC=0, second instance for PC wrap.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        misaligned;

    logic        b_rst;
    logic [31:0] b_instr;
    logic        b_instr_valid;
    logic [31:0] b_pc;
    logic [31:0] b_pc_plus4;
    logic        b_retire;
    logic [1:0]  b_pc_src;
    logic [31:0] b_imm_ext;
    logic [31:0] b_alu_result;
    logic        b_misaligned;

    fetch_unit_if ifa ();
    fetch_unit_if ifb ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(ifa.master),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .retire(retire), .pc_src(pc_src), .imm_ext(imm_ext),
        .alu_result(alu_result), .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(b_rst), .imem(ifb.master),
        .instr(b_instr), .instr_valid(b_instr_valid), .pc(b_pc), .pc_plus4(b_pc_plus4),
        .retire(b_retire), .pc_src(b_pc_src), .imm_ext(b_imm_ext),
        .alu_result(b_alu_result), .misaligned(b_misaligned)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; retire = 1'b0; pc_src = 2'b00; imm_ext = 32'd0; alu_result = 32'd0;
        ifa.imem_ack = 1'b0; ifa.imem_rdata = 32'd0;
        b_rst = 1'b1; b_retire = 1'b0; b_pc_src = 2'b00; b_imm_ext = 32'd0; b_alu_result = 32'd0;
        ifb.imem_ack = 1'b0; ifb.imem_rdata = 32'd0;
        tick(); tick();

        check_value("rst_req", 32'(ifa.imem_req), 32'd0);
        check_value("rst_valid", 32'(instr_valid), 32'd0);
        check_value("rst_instr", instr, 32'h0000_0013);
        check_value("rst_pc", pc, 32'h0000_0000);
        check_value("rst_mis", 32'(misaligned), 32'd0);
        check_value("rst_addr", ifa.imem_addr, 32'h0000_0000);

        // Reset then fetch, ack on the third request cycle
        rst = 1'b0;
        tick(); check_value("req_c1", 32'(ifa.imem_req), 32'd1);
        check_value("addr_c1", ifa.imem_addr, 32'h0000_0000);
        tick(); check_value("req_c2", 32'(ifa.imem_req), 32'd1);
        tick(); check_value("req_c3", 32'(ifa.imem_req), 32'd1);
        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h0050_0093;
        tick(); ifa.imem_ack = 1'b0;
        check_value("f1_valid", 32'(instr_valid), 32'd1);
        check_value("f1_instr", instr, 32'h0050_0093);
        check_value("f1_req", 32'(ifa.imem_req), 32'd0);
        check_value("f1_pc4", pc_plus4, 32'h0000_0004);

        // Ack outside FETCH is ignored
        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hFFFF_FFFF;
        tick(); ifa.imem_ack = 1'b0;
        check_value("ack_in_valid", instr, 32'h0050_0093);
        check_value("still_valid", 32'(instr_valid), 32'd1);

        // Sequential retire
        retire = 1'b1; pc_src = 2'b00;
        tick(); retire = 1'b0;
        check_value("seq_req", 32'(ifa.imem_req), 32'd1);
        check_value("seq_addr", ifa.imem_addr, 32'h0000_0004);
        check_value("seq_valid", 32'(instr_valid), 32'd0);

        // Ack in the first request cycle is accepted
        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h00A0_0113;
        tick(); ifa.imem_ack = 1'b0;
        check_value("fast_valid", 32'(instr_valid), 32'd1);
        check_value("fast_instr", instr, 32'h00A0_0113);

        retire = 1'b1; pc_src = 2'b11;
        tick(); retire = 1'b0;
        check_value("src11_addr", ifa.imem_addr, 32'h0000_0008);
        check_value("src11_req", 32'(ifa.imem_req), 32'd1);

        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h0000_0013;
        tick(); ifa.imem_ack = 1'b0;
        retire = 1'b1; pc_src = 2'b01; imm_ext = 32'h0000_0008;
        tick(); retire = 1'b0;
        check_value("br_fwd_addr", ifa.imem_addr, 32'h0000_0010);

        // Branch backward
        ifa.imem_ack = 1'b1;
        tick(); ifa.imem_ack = 1'b0;
        retire = 1'b1; pc_src = 2'b01; imm_ext = 32'hFFFF_FFF8;
        tick(); retire = 1'b0;
        check_value("br_back_addr", ifa.imem_addr, 32'h0000_0008);

        // JALR clears bit 0
        ifa.imem_ack = 1'b1;
        tick(); ifa.imem_ack = 1'b0;
        retire = 1'b1; pc_src = 2'b10; alu_result = 32'h0000_0101;
        tick(); retire = 1'b0;
        check_value("jalr_addr", ifa.imem_addr, 32'h0000_0100);

        // Retire during FETCH is ignored
        retire = 1'b1; pc_src = 2'b01; imm_ext = 32'h0000_0040;
        tick(); retire = 1'b0;
        check_value("ret_in_fetch_addr", ifa.imem_addr, 32'h0000_0100);
        check_value("ret_in_fetch_req", 32'(ifa.imem_req), 32'd1);

        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h0000_0067;
        tick(); ifa.imem_ack = 1'b0;
        check_value("jalr_valid", 32'(instr_valid), 32'd1);

        // Misaligned JALR target
        retire = 1'b1; pc_src = 2'b10; alu_result = 32'h0000_0106;
        tick(); retire = 1'b0;
        check_value("flt_mis", 32'(misaligned), 32'd1);
        check_value("flt_req", 32'(ifa.imem_req), 32'd0);
        check_value("flt_valid", 32'(instr_valid), 32'd0);
        check_value("flt_pc", pc, 32'h0000_0100);

        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hCAFE_BABE; retire = 1'b1; pc_src = 2'b00;
        tick(); tick();
        ifa.imem_ack = 1'b0; retire = 1'b0;
        check_value("flt_hold_mis", 32'(misaligned), 32'd1);
        check_value("flt_hold_req", 32'(ifa.imem_req), 32'd0);
        check_value("flt_hold_instr", instr, 32'h0000_0067);
        check_value("flt_hold_pc", pc, 32'h0000_0100);

        // Reset clears the fault; then reset collides with an ack
        rst = 1'b1;
        tick(); rst = 1'b0;
        check_value("clr_mis", 32'(misaligned), 32'd0);
        tick();
        check_value("mid_req_before", 32'(ifa.imem_req), 32'd1);
        rst = 1'b1; ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hDEAD_BEEF;
        tick(); rst = 1'b0; ifa.imem_ack = 1'b0;
        check_value("mid_instr", instr, 32'h0000_0013);
        check_value("mid_valid", 32'(instr_valid), 32'd0);
        check_value("mid_req", 32'(ifa.imem_req), 32'd0);
        tick();
        check_value("restart_req", 32'(ifa.imem_req), 32'd1);
        check_value("restart_addr", ifa.imem_addr, 32'h0000_0000);

        // PC wrap on the second instance
        b_rst = 1'b0;
        tick();
        check_value("wrap_req", 32'(ifb.imem_req), 32'd1);
        check_value("wrap_addr0", ifb.imem_addr, 32'hFFFF_FFFC);
        check_value("wrap_pc4", b_pc_plus4, 32'h0000_0000);
        ifb.imem_ack = 1'b1; ifb.imem_rdata = 32'h0000_0013;
        tick(); ifb.imem_ack = 1'b0;
        check_value("wrap_valid", 32'(b_instr_valid), 32'd1);
        b_retire = 1'b1; b_pc_src = 2'b00;
        tick(); b_retire = 1'b0;
        check_value("wrap_addr1", ifb.imem_addr, 32'h0000_0000);
        check_value("wrap_req1", 32'(ifb.imem_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
